// File: rtl/fp16_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fp16_mult_arbiter
// Brief   : Round-robin share of one combinational fp16 multiplier among
//           NUM_REQ requesters; 2-cycle latency, one multiply per cycle.
//           Optional macro FP16_MULT_LOCK_EN adds a per-requester burst lock.
// Revision: 1.0 - initial release
// ============================================================================
module fp16_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 31,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      iRst_n,
  input  logic                      ena,
  input  logic [NUM_REQ-1:0]        req,
`ifdef FP16_MULT_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  input  logic [NUM_REQ*DATA_W-1:0] opa,
  input  logic [NUM_REQ*DATA_W-1:0] opb,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         opr1_to_mult,
  output logic [DATA_W-1:0]         opr2_to_mult,
  input  logic [RES_W-1:0]          data_from_mult,
  output logic [RES_W-1:0]          result,
  output logic                      result_valid,
  output logic [ID_W-1:0]           result_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_s1_valid;
  logic [ID_W-1:0]   r_s1_id;
  logic [DATA_W-1:0] r_opr1;
  logic [DATA_W-1:0] r_opr2;
  logic [RES_W-1:0]  r_result;
  logic              r_result_valid;
  logic [ID_W-1:0]   r_result_id;

  logic              w_hit_hi;
  logic              w_hit_lo;
  logic [ID_W-1:0]   w_win_hi;
  logic [ID_W-1:0]   w_win_lo;
  logic [ID_W-1:0]   w_win;
  logic              w_take;
  logic              w_hold;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [DATA_W-1:0] w_opa_sel;
  logic [DATA_W-1:0] w_opb_sel;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_lock;

`ifdef FP16_MULT_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = '0;
`endif

  // Two passes give the wrap: first set bit at or above rr_ptr, else lowest set bit.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit_hi && req[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_hit_hi = 1'b1;
        w_win_hi = ID_W'(i);
      end
      if (!w_hit_lo && req[i]) begin
        w_hit_lo = 1'b1;
        w_win_lo = ID_W'(i);
      end
    end
    w_win  = w_hit_hi ? w_win_hi : w_win_lo;
    w_take = (r_state == S_ACTIVE) && ena && (w_hit_hi || w_hit_lo);
  end

  always_comb begin
    w_gnt     = '0;
    w_opa_sel = '0;
    w_opb_sel = '0;
    w_hold    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) begin
        w_gnt[i]  = w_take;
        w_opa_sel = opa[i*DATA_W +: DATA_W];
        w_opb_sel = opb[i*DATA_W +: DATA_W];
        w_hold    = w_lock[i];
      end
    end
    if (w_hold)
      w_ptr_nxt = w_win;
    else if (w_win == ID_W'(NUM_REQ-1))
      w_ptr_nxt = '0;
    else
      w_ptr_nxt = w_win + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (ena) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (!ena) w_state_nxt = (r_s1_valid || r_result_valid) ? S_DRAIN : S_IDLE;
      S_DRAIN:  if (!r_s1_valid && !r_result_valid) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_id        <= '0;
      r_opr1         <= '0;
      r_opr2         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_s1_valid <= w_take;
      // Operand registers hold when idle so the multiplier inputs stop toggling.
      if (w_take) begin
        r_rr_ptr <= w_ptr_nxt;
        r_s1_id  <= w_win;
        r_opr1   <= w_opa_sel;
        r_opr2   <= w_opb_sel;
      end
      r_result_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result    <= data_from_mult;
        r_result_id <= r_s1_id;
      end
    end
  end

  assign gnt          = w_gnt;
  assign opr1_to_mult = r_opr1;
  assign opr2_to_mult = r_opr2;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign result_id    = r_result_id;
  assign busy         = r_s1_valid | r_result_valid | (r_state == S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_fp16_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp16_mult_arbiter
// Brief   : Scoreboard bench for fp16_mult_arbiter with a concatenating
//           multiplier stub; lock scenario built when FP16_MULT_LOCK_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp16_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int RES_W   = 31;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      iRst_n = 1'b0;
  logic                      ena = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
`ifdef FP16_MULT_LOCK_EN
  logic [NUM_REQ-1:0]        lock = '0;
`endif
  logic [DATA_W-1:0]         opa_a [NUM_REQ];
  logic [DATA_W-1:0]         opb_a [NUM_REQ];
  logic [NUM_REQ*DATA_W-1:0] opa;
  logic [NUM_REQ*DATA_W-1:0] opb;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         opr1_to_mult;
  logic [DATA_W-1:0]         opr2_to_mult;
  logic [RES_W-1:0]          data_from_mult;
  logic [RES_W-1:0]          result;
  logic                      result_valid;
  logic [ID_W-1:0]           result_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  logic [ID_W+RES_W-1:0] sb [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      opa[i*DATA_W +: DATA_W] = opa_a[i];
      opb[i*DATA_W +: DATA_W] = opb_a[i];
    end
  end

  assign data_from_mult = {opr1_to_mult[14:0], opr2_to_mult};

  fp16_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .ID_W(ID_W)
  ) dut (
    .clk            (clk),
    .iRst_n         (iRst_n),
    .ena            (ena),
    .req            (req),
`ifdef FP16_MULT_LOCK_EN
    .lock           (lock),
`endif
    .opa            (opa),
    .opb            (opb),
    .gnt            (gnt),
    .opr1_to_mult   (opr1_to_mult),
    .opr2_to_mult   (opr2_to_mult),
    .data_from_mult (data_from_mult),
    .result         (result),
    .result_valid   (result_valid),
    .result_id      (result_id),
    .busy           (busy)
  );

  // Scoreboard: push on an observed grant, pop on every result_valid.
  always @(negedge clk) begin
    logic [ID_W+RES_W-1:0] exp_e;
    if (result_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result_valid=1 id=%0d result=%h, required no result", result_id, result);
      end else begin
        exp_e = sb.pop_front();
        if ({result_id, result} !== exp_e) begin
          errors++;
          $display("FAIL sb_result: got id=%0d result=%h, required id=%0d result=%h",
                   result_id, result, exp_e[ID_W+RES_W-1:RES_W], exp_e[RES_W-1:0]);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sb.push_back({ID_W'(i), opa_a[i][14:0], opb_a[i]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    iRst_n = 1'b0;
    ena    = 1'b0;
    req    = '0;
`ifdef FP16_MULT_LOCK_EN
    lock   = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      opa_a[i] = 16'($urandom);
      opb_a[i] = 16'($urandom);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 iRst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    iRst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, opr1_to_mult, opr2_to_mult, result, result_valid, result_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b o1=%h o2=%h res=%h rv=%b id=%0d busy=%b, required all 0",
               gnt, opr1_to_mult, opr2_to_mult, result, result_valid, result_id, busy);
    end
    tick();
    iRst_n = 1'b1;
  endtask

  task automatic test_basic();
    reset_dut();
    ena = 1'b1; req = 4'b0001;
    opa_a[0] = 16'h154C; opb_a[0] = 16'h174C;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b, required 0000", gnt); end
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b, required 0001", gnt); end
    tick();
    req = '0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || opr1_to_mult !== 16'h154C) begin
      errors++;
      $display("FAIL basic_t1: got rv=%b busy=%b o1=%h, required rv=0 busy=1 o1=154c", result_valid, busy, opr1_to_mult);
    end
    tick();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result !== 31'h154C174C || result_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_t2: got rv=%b res=%h id=%0d, required rv=1 res=154c174c id=0", result_valid, result, result_id);
    end
    tick();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || result !== 31'h154C174C) begin
      errors++;
      $display("FAIL basic_t3: got rv=%b res=%h, required rv=0 res=154c174c", result_valid, result);
    end
    repeat (3) tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    ena = 1'b1;
    tick();
    for (int c = 0; c < 11; c++) begin
      req = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (gnt !== 4'(1 << (c % 4))) begin
          errors++;
          $display("FAIL b2b_gnt[%0d]: got %b, required %b", c, gnt, 4'(1 << (c % 4)));
        end
      end
      checks++;
      if (result_valid !== 1'((c >= 2) && (c < 10))) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b, required %b", c, result_valid, (c >= 2) && (c < 10));
      end
      tick();
      if (c < 8) begin
        opa_a[c % 4] = 16'($urandom);
        opb_a[c % 4] = 16'($urandom);
      end
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_round_robin();
    logic [3:0] req_t [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011};
    int         exp_t [6] = '{1, 3, 1, 3, 0, 1};
    reset_dut();
    ena = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      req = req_t[c];
      @(negedge clk);
      checks++;
      if (gnt !== 4'(1 << exp_t[c])) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b, required %b", c, gnt, 4'(1 << exp_t[c]));
      end
      tick();
    end
    req = '0;
    repeat (4) tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL rr_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_ena_drop();
    reset_dut();
    ena = 1'b1;
    tick();
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL ena_gnt0: got %b, required 0001", gnt); end
    tick();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL ena_gnt1: got %b, required 0010", gnt); end
    tick();
    ena = 1'b0; req = 4'b0100;
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || result_valid !== 1'(c <= 3) || busy !== 1'(c <= 4)) begin
        errors++;
        $display("FAIL ena_drain[%0d]: got gnt=%b rv=%b busy=%b, required gnt=0000 rv=%b busy=%b",
                 c, gnt, result_valid, busy, c <= 3, c <= 4);
      end
      tick();
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL ena_idle_gnt: got %b, required 0000", gnt); end
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL ena_resume_gnt: got %b, required 0100", gnt); end
    tick();
    req = '0;
    repeat (4) tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL ena_sb_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ena = 1'b1;
    tick();
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_gnt: got %b, required 0001", gnt); end
    tick();
    req = '0;
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({opr1_to_mult, opr2_to_mult, result, result_valid, result_id, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got o1=%h o2=%h res=%h rv=%b id=%0d busy=%b, required all 0",
               opr1_to_mult, opr2_to_mult, result, result_valid, result_id, busy);
    end
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rv[%0d]: got %b, required 0", c, result_valid); end
      tick();
    end
    iRst_n = 1'b1;
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got gnt=%b rv=%b, required gnt=0000 rv=0", gnt, result_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b, required 0001", gnt); end
    tick();
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_second: got %b, required 1000", gnt); end
    tick();
    req = '0;
    repeat (4) tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL rstmid_drain: got %0d pending, required 0", sb.size()); end
  endtask

`ifdef FP16_MULT_LOCK_EN
  task automatic test_lock();
    logic lk_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int   exp_t [7] = '{0, 0, 0, 0, 1, 0, 1};
    reset_dut();
    ena = 1'b1;
    tick();
    req = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      lock = lk_t[c] ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (gnt !== 4'(1 << exp_t[c])) begin
        errors++;
        $display("FAIL lock_gnt[%0d]: got %b, required %b", c, gnt, 4'(1 << exp_t[c]));
      end
      tick();
    end
    req = '0; lock = '0;
    repeat (4) tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL lock_drain: got %0d pending, required 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_round_robin();
    test_ena_drop();
    test_reset_mid();
`ifdef FP16_MULT_LOCK_EN
    test_lock();
`endif
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
